// File: rtl/phase_timer_pkg.sv
// rtl/phase_timer_pkg.sv - shared state type and defaults for the phase timer
package phase_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 6;

endpackage

// File: rtl/load_down_counter.sv
// rtl/load_down_counter.sv - loadable down counter that saturates at zero
module load_down_counter
  import phase_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             is_one
);

  logic [WIDTH-1:0] r_q;

  // Load takes priority; decrement is blocked at zero so the count never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= load_val;
    end else if (dec && (r_q != '0)) begin
      r_q <= r_q - WIDTH'(1);
    end
  end

  assign q      = r_q;
  assign is_one = (r_q == WIDTH'(1));

endmodule

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - programmable one-shot/periodic down-timer for light phases
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] duration,
  input  logic             periodic,
  input  logic             tick_en,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             expire,
  output logic             busy
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_reload;
  logic             r_periodic;
  logic             r_expire;
  logic             w_load;
  logic [WIDTH-1:0] w_load_val;
  logic             w_dec;
  logic             w_expire_next;
  logic             w_latch;
  logic             w_is_one;

  load_down_counter #(.WIDTH(WIDTH)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .dec      (w_dec),
    .q        (count),
    .is_one   (w_is_one)
  );

  always_comb begin
    w_next_state  = r_state;
    w_load        = 1'b0;
    w_load_val    = r_reload;
    w_dec         = 1'b0;
    w_expire_next = 1'b0;
    w_latch       = 1'b0;
    if (abort) begin
      w_next_state = IDLE;
      w_load       = 1'b1;
      w_load_val   = '0;
    end else if (start) begin
      w_latch    = 1'b1;
      w_load     = 1'b1;
      w_load_val = duration;
      // A zero-length request expires at once and never auto-reloads.
      if (duration == '0) begin
        w_next_state  = IDLE;
        w_expire_next = 1'b1;
      end else begin
        w_next_state = pause ? HOLD : RUN;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (pause) begin
            w_next_state = HOLD;
          end else if (tick_en) begin
            if (w_is_one) begin
              w_expire_next = 1'b1;
              w_load        = 1'b1;
              if (!r_periodic) begin
                w_load_val   = '0;
                w_next_state = IDLE;
              end
            end else begin
              w_dec = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!pause) begin
            w_next_state = RUN;
          end
        end
        default: begin
          w_next_state = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_reload   <= '0;
      r_periodic <= 1'b0;
      r_expire   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_expire <= w_expire_next;
      if (w_latch) begin
        r_reload   <= duration;
        r_periodic <= periodic;
      end
    end
  end

  assign expire = r_expire;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_phase_timer.sv
// tb/tb_phase_timer.sv - scoreboard bench for phase_timer (WIDTH = 8)
module tb_phase_timer;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] duration;
  logic         periodic;
  logic         tick_en;
  logic         pause;
  logic         abort;
  logic [W-1:0] count;
  logic         expire;
  logic         busy;

  int n_tests;
  int n_fail;
  int cyc;
  int exp_q[$];
  int e;

  phase_timer #(.WIDTH(W)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .duration (duration),
    .periodic (periodic),
    .tick_en  (tick_en),
    .pause    (pause),
    .abort    (abort),
    .count    (count),
    .expire   (expire),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_eq(input string tag, input longint act, input longint req);
    n_tests = n_tests + 1;
    if (act != req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, req, cyc);
    end
  endtask

  // Expected expire edges are queued at stimulus time and retired here.
  always @(negedge clk) begin
    if (!reset && expire) begin
      if (exp_q.size() > 0) begin
        check_eq("expire_edge", cyc, exp_q.pop_front());
      end else begin
        check_eq("unexpected_expire", 1, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input int d, input logic per);
    start    = 1'b1;
    duration = W'(d);
    periodic = per;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; duration = '0; periodic = 1'b0;
    tick_en = 1'b0; pause = 1'b0; abort = 1'b0;
    repeat (2) step();
    check_eq("rst_count", count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_expire", expire, 0);
    reset = 1'b0;
    step();

    // One-shot, duration 5, continuous ticks.
    tick_en = 1'b1;
    drive_start(5, 1'b0);
    exp_q.push_back(cyc + 1 + 5);
    for (int k = 0; k <= 5; k++) begin
      step();
      start = 1'b0;
      check_eq("oneshot_count", count, 5 - k);
    end
    check_eq("oneshot_busy_after", busy, 0);
    tick_en = 1'b0;
    repeat (3) step();

    // Periodic, duration 3, tick every 4th cycle; duration input changed mid-run.
    drive_start(3, 1'b1);
    e = cyc + 1;
    exp_q.push_back(e + 12); exp_q.push_back(e + 24); exp_q.push_back(e + 36);
    step();
    start = 1'b0;
    duration = W'(7);
    check_eq("per_load", count, 3);
    for (int i = 1; i <= 36; i++) begin
      tick_en = (i % 4 == 0);
      step();
      check_eq("per_busy", busy, 1);
      if (i % 12 == 0) check_eq("per_reload", count, 3);
    end
    tick_en = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("per_abort_busy", busy, 0);
    check_eq("per_abort_count", count, 0);
    repeat (2) step();

    // Pause 7 cycles at count 6; one extra cycle to leave HOLD.
    tick_en = 1'b1;
    drive_start(10, 1'b0);
    e = cyc + 1;
    exp_q.push_back(e + 18);
    step();
    start = 1'b0;
    repeat (4) step();
    check_eq("pause_pre", count, 6);
    pause = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq("pause_hold", count, 6);
      check_eq("pause_busy", busy, 1);
    end
    pause = 1'b0;
    step();
    check_eq("pause_resume_edge", count, 6);
    step();
    check_eq("pause_first_dec", count, 5);
    repeat (5) step();
    check_eq("pause_end_count", count, 0);
    check_eq("pause_end_busy", busy, 0);
    step();

    // Abort at count 4: no expire.
    drive_start(7, 1'b0);
    step();
    start = 1'b0;
    repeat (3) step();
    check_eq("abort_pre", count, 4);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_count", count, 0);
    check_eq("abort_busy", busy, 0);
    repeat (3) step();

    // Start and abort together: abort wins.
    drive_start(5, 1'b0);
    abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check_eq("startabort_busy", busy, 0);
    check_eq("startabort_count", count, 0);
    step();

    // Restart during RUN with duration 2.
    drive_start(9, 1'b0);
    step();
    start = 1'b0;
    repeat (3) step();
    check_eq("restart_pre", count, 6);
    drive_start(2, 1'b0);
    exp_q.push_back(cyc + 1 + 2);
    step();
    start = 1'b0;
    check_eq("restart_load", count, 2);
    step();
    check_eq("restart_mid", count, 1);
    step();
    check_eq("restart_end", count, 0);
    check_eq("restart_busy", busy, 0);
    step();

    // Zero duration with periodic set: single expire, stays idle.
    drive_start(0, 1'b1);
    exp_q.push_back(cyc + 1);
    step();
    start = 1'b0;
    check_eq("zero_busy", busy, 0);
    check_eq("zero_count", count, 0);
    repeat (4) step();

    // Full-scale 255 ticks.
    drive_start(255, 1'b0);
    exp_q.push_back(cyc + 1 + 255);
    step();
    start = 1'b0;
    check_eq("max_load", count, 255);
    repeat (254) step();
    check_eq("max_one", count, 1);
    step();
    check_eq("max_end", count, 0);
    check_eq("max_busy", busy, 0);
    step();

    // Asynchronous reset mid-run at count 9.
    tick_en = 1'b0;
    drive_start(9, 1'b1);
    step();
    start = 1'b0;
    check_eq("arst_pre_count", count, 9);
    check_eq("arst_pre_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_count", count, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_expire", expire, 0);
    step();
    reset = 1'b0;
    tick_en = 1'b1;
    repeat (12) step();

    check_eq("pending_expires", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
Parametrised programmable down-timer; the next generation of the fixed 6-bit free-running counter used for traffic-light phase timing.
- Loads a programmable duration and counts it down on an external tick strobe.
- Supports pause, abort, and one-shot or periodic (auto-reload) modes.
- Emits a single-cycle expire pulse.
- Sits between the tick prescaler and the light-sequencing FSM. Each light phase (green/amber/red/all-red) arms one timer.

Parameters:
WIDTH, 6, bit width of duration and count; legal range 2..32.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request: load duration and begin timing
duration  input  WIDTH  ticks to time; sampled only on the cycle start is high
periodic  input  1  sampled with start: 1 = auto-reload on expiry, 0 = one-shot
tick_en  input  1  count strobe from the prescaler; count advances only when high
pause  input  1  level; freezes the count while high
abort  input  1  one-cycle request: stop immediately without expiry
count  output  WIDTH  remaining ticks (registered)
expire  output  1  one-cycle pulse when the count reaches its end
busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: reset is asynchronous and active-high; clock is clk. All state is updated on the rising edge of clk.
- On reset:
  - state = IDLE; count = 0; expire = 0; busy = 0.
  - Latched reload value = 0; latched periodic flag = 0.
- States:
  - IDLE: not timing.
  - RUN: decrementing on tick_en.
  - HOLD: paused, count frozen.
- Event priority each cycle: abort > start > pause/tick logic.
- abort, from any state: next state IDLE, count = 0, expire = 0. A pending start in the same cycle is ignored.
- start, from any state including RUN or HOLD (restart):
  - Latch duration into the reload register and latch periodic.
  - Set count = duration.
  - Next state is HOLD if pause = 1, otherwise RUN.
  - tick_en in the start cycle is ignored, so there is no decrement on the load edge.
- start with duration = 0: next state IDLE, count = 0, expire = 1 for one cycle, regardless of periodic. Zero-length periodic timing is not allowed.
- RUN:
  - If pause = 1: go to HOLD, with no decrement even if tick_en = 1.
  - Else if tick_en = 1 and count > 1: count decrements by 1.
  - Else if tick_en = 1 and count == 1 (expiry):
    - expire = 1 for the next cycle only.
    - If the latched periodic flag = 1: count = reload value and stay in RUN.
    - Otherwise: count = 0 and go to IDLE.
- HOLD:
  - count is frozen and tick_en is ignored.
  - When pause = 0: return to RUN. Counting resumes on the first tick_en of the following cycle.
- Latency: with continuous tick_en, expire is high in the cycle following the D-th tick edge after the start edge. Its timing is exactly D ticks, with no off-by-one.
- Arithmetic:
  - count never underflows and never wraps.
  - Reload uses the latched value. Changes on the duration input during RUN have no effect.
- Outputs:
  - expire is registered.
  - busy = (state != IDLE), registered-equivalent (decoded from state flops).
  - In periodic mode, busy stays high across expiry.
- Reset asserted mid-run: reset takes effect immediately (asynchronous), and no expire is generated.

Decomposition:
- Package phase_timer_pkg holds:
  - state typedef enum logic [1:0] {IDLE, RUN, HOLD};
  - localparam DEFAULT_WIDTH = 6.
- Sub-module load_down_counter holds the WIDTH-parameterised count register:
  - Inputs: load, load_val, dec.
  - Outputs: q, is_one.
  - Uses the same asynchronous reset.
- The FSM, reload register, periodic latch and expire pulse stay in phase_timer.

Test Plan:
- Reset check: assert reset mid-RUN with count = 9 → count = 0, busy = 0, expire = 0 immediately, before the next clock edge.
- One-shot run: start, duration = 5, periodic = 0, tick_en held 1 → count goes 5,4,3,2,1,0; expire is high for exactly one cycle after the 5th tick; busy is low afterward.
- Periodic run with sparse ticks: duration = 3, periodic = 1, tick_en every 4th cycle → expire every 3 ticks (every 12 cycles); count reloads 3; busy stays 1; three consecutive periods are checked.
- Pause: duration = 10; pause for 7 cycles at count = 6 with tick_en = 1 → count holds 6; counting resumes after pause drops; total expire delay = 10 ticks plus pause time.
- Abort and restart:
  - abort at count = 4 → IDLE, count = 0, no expire.
  - start and abort in the same cycle → abort wins.
  - start during RUN with duration = 2 → count reloads 2 and expires 2 ticks later.
- Boundaries:
  - start with duration = 0, periodic = 1 → single expire, state IDLE.
  - WIDTH = 8, duration = 255 → 255 ticks to expire, with no wrap.
